mux_scan_ctrl: RTL
==================

MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 SHALL have parameter: DWELL_W, default 8, width of dwell count.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port: en  input  1  scan enable.
REQ-005 SHALL have port: ch_mask  input  4  per-channel enable; bit i enables mux channel i.
REQ-006 SHALL have port: dwell  input  DWELL_W  cycles per channel minus one.
REQ-007 SHALL have port: force_vld  input  1  manual override request.
REQ-008 SHALL have port: force_sel  input  2  channel selected while force_vld=1.
REQ-009 SHALL have port: select  output  2  drives the 4:1 mux select.
REQ-010 SHALL have port: sel_vld  output  1  select is meaningful.
REQ-011 SHALL have port: frame_start  output  1  one-cycle pulse at the start of each scan frame.

Function
REQ-012 SHALL register all outputs; each input change affects outputs one cycle later.
REQ-013 SHALL implement FSM states IDLE, SCAN, FORCE.
REQ-014 IDLE: select=0, sel_vld=0, frame_start=0.
REQ-015 IDLE->SCAN when en=1 and ch_mask!=0; next cycle select=lowest enabled channel, sel_vld=1, frame_start=1, dwell counter loaded with dwell.
REQ-016 SCAN: dwell counter decrements by 1 per cycle; on count==0, next cycle select=next enabled channel in ascending order, wrapping 3->0, and counter reloads with dwell.
REQ-017 frame_start SHALL pulse for exactly one cycle whenever the newly selected channel index <= the previous index (wrap).
REQ-018 Single enabled channel: select holds; frame_start pulses at every dwell expiry.
REQ-019 dwell=0: select advances every cycle.
REQ-020 dwell SHALL be sampled only at counter load; mid-dwell changes take effect at the next load.
REQ-021 ch_mask change mid-dwell: current channel completes its dwell even if now disabled; next channel chosen from the new mask.
REQ-022 ch_mask==0 at dwell expiry: SCAN->IDLE.
REQ-023 en=0 in SCAN: ->IDLE next cycle regardless of counter.
REQ-024 force_vld=1 in any state: ->FORCE next cycle; select=force_sel tracked each cycle; sel_vld=1; frame_start=0; scan channel saved; counter frozen.
REQ-025 force_vld priority SHALL exceed en and dwell expiry when they coincide.
REQ-026 FORCE exit (force_vld=0): ->SCAN at saved channel with counter reloaded if en=1 and ch_mask!=0, else ->IDLE; frame_start not pulsed on resume.
REQ-027 Entering FORCE from IDLE: saved channel = lowest enabled channel at exit.

Reset
REQ-028 rst_n=0 SHALL asynchronously force state=IDLE, select=0, sel_vld=0, frame_start=0, counter=0, saved channel=0.
REQ-029 Reset asserted mid-scan or mid-force SHALL abort immediately; first SCAN entry after release behaves as REQ-015.

Structure
REQ-030 Package mux_scan_pkg SHALL hold state enum (IDLE, SCAN, FORCE), CH_N=4, SEL_W=2.
REQ-031 Combinational sub-module rr_next4 SHALL compute next enabled index and wrap flag from current index and mask; instantiated once.

Verification
REQ-032 mask=4'b1111, dwell=2, en=1 -> select 0,0,0,1,1,1,2,2,2,3,3,3,0; frame_start at first 0 and at wrap.
REQ-033 mask=4'b1010, dwell=0 -> select 1,3,1,3; frame_start on every 1.
REQ-034 Mid-dwell on channel 1, mask 4'b1111->4'b0100 -> channel 1 finishes dwell, then select=2 held, frame_start each expiry.
REQ-035 force_vld=1, force_sel=3 during channel 2 with 1 count left -> select=3 next cycle; release -> select=2 with full dwell, no frame_start.
REQ-036 mask->0 during scan -> IDLE at expiry, sel_vld=0; en=0 -> IDLE in one cycle.
REQ-037 rst_n low mid-scan -> outputs 0 immediately without clock edge; restart yields frame_start on lowest enabled channel.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the 4:1 mux scan controller.
//   state_t : controller state (IDLE, SCAN, FORCE)
//   CH_N    : number of mux channels
//   SEL_W   : width of a channel index
package mux_scan_pkg;
    localparam int CH_N  = 4;
    localparam int SEL_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        FORCE = 2'd2
    } state_t;
endpackage

// File: rtl/rr_next4.sv
// Round-robin helper: finds the next enabled channel strictly after cur,
// searching in ascending order and wrapping 3->0. With a single enabled
// channel equal to cur, the search comes back to cur itself.
//   cur  : current channel index
//   mask : per-channel enable
//   nxt  : next enabled channel (cur when mask is all zero)
//   wrap : nxt <= cur, i.e. the scan wrapped into a new frame
module rr_next4
    import mux_scan_pkg::*;
(
    input  logic [SEL_W-1:0] cur,
    input  logic [CH_N-1:0]  mask,
    output logic [SEL_W-1:0] nxt,
    output logic             wrap
);

    logic [SEL_W-1:0] cand [CH_N];
    logic [CH_N-1:0]  hit;

    // cand[gi] is the channel gi+1 steps after cur; the modulo-4 wrap
    // falls out of the 2-bit addition.
    generate
        for (genvar gi = 0; gi < CH_N; gi++) begin : g_cand
            assign cand[gi] = cur + SEL_W'(gi + 1);
            assign hit[gi]  = mask[cand[gi]];
        end
    endgenerate

    // Nearest hit wins: iterate from farthest to nearest so the closest
    // enabled candidate is the last one assigned.
    always_comb begin
        nxt = cur;
        for (int k = CH_N - 1; k >= 0; k--) begin
            if (hit[k]) begin
                nxt = cand[k];
            end
        end
    end

    assign wrap = (nxt <= cur);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan controller for a 4:1 mux. Steps through the enabled channels in
// ascending order, holding each for dwell+1 cycles, and flags the start of
// every scan frame. A manual override can pin the select to any channel;
// when released, scanning resumes on the channel it interrupted.
//   clk, rst_n  : clock, asynchronous active-low reset
//   en          : scan enable
//   ch_mask     : per-channel enable
//   dwell       : cycles per channel minus one (sampled at counter load)
//   force_vld   : manual override request
//   force_sel   : channel driven while overriding
//   select      : registered mux select
//   sel_vld     : select is meaningful
//   frame_start : one-cycle pulse when a new scan frame begins
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [3:0]         ch_mask,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               force_vld,
    input  logic [1:0]         force_sel,
    output logic [1:0]         select,
    output logic               sel_vld,
    output logic               frame_start
);

    state_t             state_reg, state_next;
    logic [SEL_W-1:0]   select_next;
    logic               sel_vld_next;
    logic               frame_start_next;
    logic [DWELL_W-1:0] cnt_reg, cnt_next;
    logic [SEL_W-1:0]   saved_reg, saved_next;
    // Clear when the override was entered from IDLE: there is no
    // interrupted channel, so resume picks the lowest enabled channel.
    logic               saved_vld_reg, saved_vld_next;

    logic               mask_any;
    logic [SEL_W-1:0]   rr_cur, rr_nxt;
    logic               rr_wrap;

    assign mask_any = |ch_mask;

    // In SCAN the helper advances from the live select. Elsewhere it is fed
    // the top channel, so its "next after 3" answer is the lowest enabled one.
    assign rr_cur = (state_reg == SCAN) ? select : SEL_W'(CH_N - 1);

    rr_next4 u_rr_next4 (
        .cur  (rr_cur),
        .mask (ch_mask),
        .nxt  (rr_nxt),
        .wrap (rr_wrap)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            select        <= '0;
            sel_vld       <= 1'b0;
            frame_start   <= 1'b0;
            cnt_reg       <= '0;
            saved_reg     <= '0;
            saved_vld_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            select        <= select_next;
            sel_vld       <= sel_vld_next;
            frame_start   <= frame_start_next;
            cnt_reg       <= cnt_next;
            saved_reg     <= saved_next;
            saved_vld_reg <= saved_vld_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        select_next      = select;
        sel_vld_next     = sel_vld;
        frame_start_next = 1'b0;
        cnt_next         = cnt_reg;
        saved_next       = saved_reg;
        saved_vld_next   = saved_vld_reg;

        // Override takes precedence over enable and dwell expiry; the
        // counter is left untouched because resume reloads it anyway.
        if (force_vld) begin
            state_next   = FORCE;
            select_next  = force_sel;
            sel_vld_next = 1'b1;
            if (state_reg == SCAN) begin
                saved_next     = select;
                saved_vld_next = 1'b1;
            end else if (state_reg == IDLE) begin
                saved_vld_next = 1'b0;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (en && mask_any) begin
                        state_next       = SCAN;
                        select_next      = rr_nxt;
                        sel_vld_next     = 1'b1;
                        frame_start_next = 1'b1;
                        cnt_next         = dwell;
                    end else begin
                        select_next  = '0;
                        sel_vld_next = 1'b0;
                    end
                end
                SCAN: begin
                    if (!en || (cnt_reg == '0 && !mask_any)) begin
                        state_next   = IDLE;
                        select_next  = '0;
                        sel_vld_next = 1'b0;
                    end else if (cnt_reg == '0) begin
                        select_next      = rr_nxt;
                        frame_start_next = rr_wrap;
                        cnt_next         = dwell;
                    end else begin
                        cnt_next = cnt_reg - DWELL_W'(1);
                    end
                end
                FORCE: begin
                    if (en && mask_any) begin
                        state_next   = SCAN;
                        select_next  = saved_vld_reg ? saved_reg : rr_nxt;
                        sel_vld_next = 1'b1;
                        cnt_next     = dwell;
                    end else begin
                        state_next   = IDLE;
                        select_next  = '0;
                        sel_vld_next = 1'b0;
                    end
                end
                default: begin
                    state_next   = IDLE;
                    select_next  = '0;
                    sel_vld_next = 1'b0;
                end
            endcase
        end
    end

endmodule
